uart_rx_frame: RTL
==================

Name: uart_rx_frame

Overview:
- Parametrised next-generation UART receiver: oversampled bit timing, configurable data bits, parity mode and stop bits.
- Reports parity, framing and overrun errors; delivers each word through a valid/ready holding register.
- Sits between the serial pin and the main bus or consuming module; supersedes the fixed 8-bit, one-clock-per-bit receiver.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first
CLKS_PER_BIT, 16, clk cycles per bit period, even, legal >= 4
PARITY_EN, 1, 1 = parity bit present after data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits checked, 1 or 2

Ports:
clk  input  1  clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
u_rx  input  1  serial line, asynchronous, idle high
en_rx  input  1  receive enable
rx_data  output  DATA_BITS  received word, valid while rx_valid=1
rx_valid  output  1  word available in the holding register
rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready at a clk edge
rx_par_err  output  1  parity mismatch on the held word
rx_frm_err  output  1  a stop bit sampled low on the held word
rx_overrun  output  1  held word overwrote an unconsumed word
rx_busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, synchronizer flops=1, counters=0. All outputs are 0: rx_data, rx_valid, all three error flags, rx_busy.
- Input: u_rx passes through a 2-flop synchronizer (reset value 1). All sampling uses the synchronized value s_rx.
- Let H = CLKS_PER_BIT/2 and N = DATA_BITS + PARITY_EN + STOP_BITS.
- IDLE: a falling edge of s_rx (previous=1, current=0) while en_rx=1 moves the state to START and clears the cycle counter.
- START: sample at cycle H after detection.
  - s_rx=1: false start, go to IDLE; no output change.
  - s_rx=0: go to DATA.
- DATA: samples at mid-bit, every CLKS_PER_BIT cycles. Bit i fills shift-register position i (LSB first). After DATA_BITS samples, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: one sample p.
  - Even parity: error when (XOR of data) ^ p = 1.
  - Odd parity: error when (XOR of data) ^ p = 0.
- STOP: STOP_BITS samples; any low sample sets the frame's framing error.
- After the last stop sample, go to IDLE in the same cycle. A start edge arriving 1 cycle later is accepted.
- Timing: the last sample falls at detection + H + N*CLKS_PER_BIT cycles. The holding register loads on the next edge, so rx_valid rises 1 cycle after the last sample.
- Errored frames are still delivered, with their flags set.
- Holding register load (once per frame):
  - rx_data, rx_par_err and rx_frm_err are written together; rx_valid=1.
  - rx_overrun=1 if rx_valid=1 and rx_ready=0 at load, else 0.
- Handshake:
  - rx_valid stays high until rx_valid & rx_ready at an edge; that edge clears rx_valid and all three flags.
  - Load and accept on the same edge: the load wins. rx_valid stays 1 with the new word, and rx_overrun=0 because the old word was taken.
- en_rx deasserted during START/DATA/PARITY/STOP: abort to IDLE next edge and discard the partial frame. The holding register is untouched.
- en_rx low in IDLE: falling edges are ignored.
- rx_data is driven only from the holding register; it is not gated by state.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample (start, data, parity, stop) is the 2-of-3 majority of s_rx at mid-1, mid and mid+1. The decision is taken at mid+1, which shifts all timing above by +1 cycle, including rx_valid.
- Undefined: single sample at mid.

Decomposition:
- Package uart_pkg holds:
  - the rx state enum: IDLE, START, DATA, PARITY, STOP;
  - localparam widths (counter width = clog2(CLKS_PER_BIT), bit-index width = clog2(DATA_BITS+1));
  - parity-mode constants.
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detect, outputs s_rx and fall. Reset value 1.

Test Plan (CLKS_PER_BIT=16, DATA_BITS=8, PARITY_EN=1 even, STOP_BITS=1, rx_ready=1):
- Frame 0xA5, parity 0, stop 1 -> rx_valid 1 cycle after stop-bit mid sample, rx_data=0xA5, all error flags 0.
- Frame 0x3C, parity 1 -> rx_data=0x3C, rx_par_err=1, rx_frm_err=0.
- Frame 0x81, parity 0, stop 0 -> rx_frm_err=1, then next frame 0x7E received cleanly.
- Low glitch of 4 clk on an idle line -> START aborts at cycle H, rx_busy returns 0, rx_valid stays 0.
- rx_ready=0, frames 0x11 then 0x22 back-to-back -> rx_data=0x22, rx_overrun=1; rx_ready pulse clears rx_valid and rx_overrun.
- en_rx dropped mid-data of 0x55, then rst_n pulsed low mid-frame -> no rx_valid; outputs reset immediately; next frame 0xC3 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types, constants and width helpers for the UART receiver.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic c_PARITY_EVEN = 1'b0;
    localparam logic c_PARITY_ODD  = 1'b1;

    // Widths depend on module parameters, so they are computed per instance.
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

    function automatic int idx_width(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Purpose  : Two-flop synchronizer for the serial line plus falling-edge detect.
// Revision : 1.0
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic u_rx,
    output logic s_rx,
    output logic fall
);

    logic r_meta;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            s_rx   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= u_rx;
            s_rx   <= r_meta;
            r_prev <= s_rx;
        end
    end

    assign fall = r_prev & ~s_rx;

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : Oversampled UART receiver with parity/framing/overrun reporting
//            and a valid/ready holding register. Optional macro
//            UART_RX_MAJORITY_EN enables 2-of-3 majority sampling.
// Revision : 1.0
// ============================================================================
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 u_rx,
    input  logic                 en_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_par_err,
    output logic                 rx_frm_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

    localparam int c_CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int c_IDX_W = idx_width(DATA_BITS);
    localparam int c_HALF  = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int c_FIRST = c_HALF;
`else
    localparam int c_FIRST = c_HALF - 1;
`endif
    localparam logic [c_CNT_W-1:0] c_FIRST_CNT = c_CNT_W'(c_FIRST);
    localparam logic [c_CNT_W-1:0] c_BIT_CNT   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_DATA = c_IDX_W'(DATA_BITS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_STOP = c_IDX_W'(STOP_BITS - 1);
    localparam logic               c_PAR_MODE  = (PARITY_ODD != 0) ? c_PARITY_ODD : c_PARITY_EVEN;

    rx_state_t              r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_err;
    logic                   r_frm_err;
    logic                   r_done;
    logic                   w_s_rx;
    logic                   w_fall;
    logic                   w_sample;
    logic                   w_tick;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .u_rx  (u_rx),
        .s_rx  (w_s_rx),
        .fall  (w_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hist <= 2'b11;
        else        r_hist <= {r_hist[0], w_s_rx};
    end

    // Decision at mid+1: r_hist[1]=mid-1, r_hist[0]=mid, w_s_rx=mid+1.
    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_s_rx) | (r_hist[0] & w_s_rx);
`else
    assign w_sample = w_s_rx;
`endif

    assign w_tick  = (r_state == START) ? (r_cnt == c_FIRST_CNT) : (r_cnt == c_BIT_CNT);
    assign rx_busy = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state != IDLE && !en_rx) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (r_state == IDLE) begin
                if (en_rx && w_fall) begin
                    r_state   <= START;
                    r_cnt     <= '0;
                    r_idx     <= '0;
                    r_par_err <= 1'b0;
                    r_frm_err <= 1'b0;
                end
            end else if (!w_tick) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
                case (r_state)
                    START: r_state <= w_sample ? IDLE : DATA;
                    DATA: begin
                        // LSB first: after DATA_BITS shifts bit i sits at position i.
                        r_shift <= {w_sample, r_shift[DATA_BITS-1:1]};
                        if (r_idx == c_LAST_DATA) begin
                            r_idx   <= '0;
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                    PARITY: begin
                        r_par_err <= (^r_shift) ^ w_sample ^ c_PAR_MODE;
                        r_state   <= STOP;
                    end
                    STOP: begin
                        if (!w_sample) r_frm_err <= 1'b1;
                        if (r_idx == c_LAST_STOP) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + c_IDX_W'(1);
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Holding register: a load takes priority over a same-edge accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_par_err <= 1'b0;
            rx_frm_err <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (r_done) begin
            rx_data    <= r_shift;
            rx_valid   <= 1'b1;
            rx_par_err <= r_par_err;
            rx_frm_err <= r_frm_err;
            rx_overrun <= rx_valid & ~rx_ready;
        end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            rx_par_err <= 1'b0;
            rx_frm_err <= 1'b0;
            rx_overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire
